// File: rtl/bcd_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_ctl_pkg
// Description : Shared types and constants for the BCD adder control block:
//               FSM state encoding and error-code values.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_ctl_pkg;

    // Controller states, 4-bit encoding also exported on state_out for debug
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_GET_A   = 4'd1,
        ST_LD_A    = 4'd2,
        ST_GET_B   = 4'd3,
        ST_LD_B    = 4'd4,
        ST_LD_CIN  = 4'd5,
        ST_CHECK   = 4'd6,
        ST_LD_RSLT = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERROR   = 4'd9
    } state_t;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // States in which the controller is waiting for an operand entry
    function automatic logic is_get_state(input state_t s);
        return (s == ST_GET_A) || (s == ST_GET_B);
    endfunction

endpackage : bcd_ctl_pkg
`default_nettype wire

// File: rtl/bcd_ctl_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_ctl_timer
// Description : Operand-entry timeout counter. Clears while clr is high,
//               counts each cycle en is high, and flags expired while the
//               count sits at TIMEOUT_CYCLES-1 with en asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_ctl_timer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] C_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_cnt;

    // Wait counter; saturates at the last count so it can never wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != C_LAST)) begin
            r_cnt <= r_cnt + TMR_W'(1);
        end
    end

    assign expired = en && (r_cnt == C_LAST);

endmodule : bcd_ctl_timer
`default_nettype wire

// File: rtl/bcd_adder8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_adder8_ctrl
// Description : Control FSM in front of the 8-bit BCD adder datapath.
//               Captures operands A and B and a carry-in from the switch
//               bus on operator enter pulses, issues the datapath load
//               strobes A, B, CIN in turn, checks the datapath range flag
//               and either commits the result or raises an error.
//               Optional operand-entry timeout: define BCD_CTL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_adder8_ctrl
    import bcd_ctl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       enter,
    input  logic [7:0] sw_in,
    input  logic       cin_in,
    input  logic       out_of_range,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       carry_in,
    output logic       load_A,
    output logic       load_B,
    output logic       load_CIN,
    output logic       load_RSLT,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [3:0] state_out
);

    state_t r_state;
    state_t w_next_state;
    logic   w_timeout;
    logic   w_cap_a;
    logic   w_cap_b;
    logic   w_start_ok;
    logic   w_range_err;
    logic   w_tmo_err;

    // Elaboration-time guard: the counter must be able to reach TIMEOUT_CYCLES-1
    if ((TIMEOUT_CYCLES < 2) || (TMR_W < $clog2(TIMEOUT_CYCLES))) begin : g_param_check
        $error("bcd_adder8_ctrl: TMR_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef BCD_CTL_TIMEOUT_EN
    logic w_tmr_en;
    logic w_tmr_clr;

    // Counter runs only while waiting for an entry; any other state clears it,
    // so it restarts at zero on every entry into GET_A or GET_B
    assign w_tmr_en  = is_get_state(r_state);
    assign w_tmr_clr = !w_tmr_en;

    bcd_ctl_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_timeout)
    );
`else
    // Without the timeout option the GET states wait indefinitely
    assign w_timeout = 1'b0;
`endif

    // Qualified events; abort overrides every transition and register update
    assign w_cap_a     = !abort && (r_state == ST_GET_A) && enter;
    assign w_cap_b     = !abort && (r_state == ST_GET_B) && enter;
    assign w_start_ok  = !abort && ((r_state == ST_IDLE) || (r_state == ST_ERROR)) && start;
    assign w_range_err = !abort && (r_state == ST_CHECK) && out_of_range;
    // An enter on the expiry cycle wins over the timeout
    assign w_tmo_err   = !abort && is_get_state(r_state) && !enter && w_timeout;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_next_state = ST_GET_A;
                end
                ST_GET_A: begin
                    if (enter)          w_next_state = ST_LD_A;
                    else if (w_timeout) w_next_state = ST_ERROR;
                end
                ST_LD_A: begin
                    w_next_state = ST_GET_B;
                end
                ST_GET_B: begin
                    if (enter)          w_next_state = ST_LD_B;
                    else if (w_timeout) w_next_state = ST_ERROR;
                end
                ST_LD_B: begin
                    w_next_state = ST_LD_CIN;
                end
                ST_LD_CIN: begin
                    w_next_state = ST_CHECK;
                end
                ST_CHECK: begin
                    if (out_of_range) w_next_state = ST_ERROR;
                    else              w_next_state = ST_LD_RSLT;
                end
                ST_LD_RSLT: begin
                    w_next_state = ST_DONE;
                end
                ST_DONE: begin
                    w_next_state = ST_IDLE;
                end
                ST_ERROR: begin
                    if (start) w_next_state = ST_GET_A;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register; at most one strobe per state
    always_comb begin
        load_A    = 1'b0;
        load_B    = 1'b0;
        load_CIN  = 1'b0;
        load_RSLT = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (r_state)
            ST_IDLE: begin
            end
            ST_GET_A: begin
                busy = 1'b1;
            end
            ST_LD_A: begin
                busy   = 1'b1;
                load_A = 1'b1;
            end
            ST_GET_B: begin
                busy = 1'b1;
            end
            ST_LD_B: begin
                busy   = 1'b1;
                load_B = 1'b1;
            end
            ST_LD_CIN: begin
                busy     = 1'b1;
                load_CIN = 1'b1;
            end
            ST_CHECK: begin
                busy = 1'b1;
            end
            ST_LD_RSLT: begin
                busy      = 1'b1;
                load_RSLT = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Operand, carry and error-code registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A        <= 8'h00;
            B        <= 8'h00;
            carry_in <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (w_cap_a) begin
                A <= sw_in;
            end
            if (w_cap_b) begin
                B <= sw_in;
            end
            // Carry captured on the LD_B cycle and then held through DONE
            if (!abort && (r_state == ST_LD_B)) begin
                carry_in <= cin_in;
            end
            if (w_start_ok) begin
                err_code <= ERR_NONE;
            end else if (w_range_err) begin
                err_code <= ERR_RANGE;
            end else if (w_tmo_err) begin
                err_code <= ERR_TIMEOUT;
            end
        end
    end

    assign state_out = r_state;

endmodule : bcd_adder8_ctrl
`default_nettype wire
